ocp_slave_mem: RTL and testbench
================================

OCP_SLAVE_MEM -- requirements
Module: ocp_slave_mem

Interface
REQ-001 Parameters (name, default, meaning), one per line:
  - TAGI_WIDTH, 5, tag width.
  - INFO_WIDTH, 4, request-info width.
  - BLEN_WIDTH, 4, burst-length width.
  - DATA_WIDTH, 32, data width.
  - ADDR_WIDTH, 5, word-address width; depth 2**ADDR_WIDTH words.
REQ-002 Ports (name, direction, width, meaning), one per line:
  - clk, in, 1, sole clock, rising edge.
  - rst_n, in, 1, asynchronous active-low reset.
  - m_addr, in, ADDR_WIDTH, start word address.
  - m_burst_length, in, BLEN_WIDTH, beats.
  - m_burst_seq, in, 3, burst sequence.
  - m_byteen, in, DATA_WIDTH/8, request byte enables (ignored).
  - m_cmd, in, 3, command.
  - m_data, in, DATA_WIDTH, write data.
  - m_data_byteen, in, DATA_WIDTH/8, write byte enables.
  - m_data_last, in, 1, last write beat.
  - m_data_tagid, in, TAGI_WIDTH, write-data tag (ignored).
  - m_data_valid, in, 1, write beat valid.
  - m_req_info, in, INFO_WIDTH, ignored.
  - m_resp_accept, in, 1, master takes response.
  - m_tagid, in, TAGI_WIDTH, request tag.
  - s_cmd_accept, out, 1, command accepted.
  - s_data, out, DATA_WIDTH, read data.
  - s_data_accept, out, 1, write beat accepted.
  - s_resp, out, 2, response code.
  - s_resp_last, out, 1, last response beat.
  - s_tagid, out, TAGI_WIDTH, response tag.
REQ-003 One clock domain; clk is the only clock; rst_n is asynchronous assert, active-low.

Function
REQ-004 Encodings:
  - m_cmd: IDLE=3'b000, WR=3'b001, RD=3'b010; all other values are unsupported.
  - s_resp: NULL=2'b00, DVA=2'b01, ERR=2'b11.
  - Burst sequence INCR=3'b000.
REQ-005 FSM states: IDLE, WR_DATA, WR_RESP, RD_RESP, ERR_RESP.
REQ-006 s_cmd_accept SHALL be 1 only in IDLE (combinational from state); a command transfers when m_cmd!=IDLE and s_cmd_accept=1.
REQ-007 On transfer, the block SHALL capture addr, burst length, tag, and an error flag. The error flag is set when m_burst_seq!=INCR, m_burst_length==0, or m_cmd is unsupported.
REQ-008 Next state after transfer:
  - WR -> WR_DATA.
  - RD without error -> RD_RESP.
  - Unsupported cmd -> ERR_RESP.
  - RD with error -> ERR_RESP.
REQ-009 In WR_DATA, s_data_accept SHALL be 1.
  - Each beat with m_data_valid=1 SHALL write bytes of m_data selected by m_data_byteen to mem[(addr+beat) mod depth], with no write if the error flag is set.
  - beat increments by 1 per beat.
REQ-010 WR_DATA ends on the beat with m_data_last=1, or on beat number burst_length, whichever comes first.
  - Leaving, the error flag is set if m_data_last and the beat count disagree.
  - Next state: WR_RESP if no error, else ERR_RESP.
REQ-011 WR_RESP SHALL drive s_resp=DVA, s_resp_last=1, s_tagid=captured tag, held until m_resp_accept=1, then IDLE.
REQ-012 RD_RESP SHALL emit burst_length beats, each held stable until m_resp_accept=1:
  - s_resp=DVA.
  - s_data=mem[(addr+beat) mod depth].
  - s_tagid=captured tag.
  - s_resp_last=1 on the final beat only.
  - After the final accepted beat, the next state is IDLE.
REQ-013 The first read beat SHALL be valid the cycle after command transfer; with m_resp_accept held at 1, beats issue back-to-back, one per cycle.
REQ-014 ERR_RESP SHALL emit a single beat, s_resp=ERR, s_resp_last=1, s_data=0, held until m_resp_accept=1, with no memory effect.
REQ-015 Address arithmetic SHALL be ADDR_WIDTH bits, wrapping from 2**ADDR_WIDTH-1 to 0; the beat counter SHALL be BLEN_WIDTH bits.
REQ-016 When not driving a response, s_resp=NULL, s_resp_last=0, s_data=0, and s_tagid=0.
REQ-017 At most one transaction is outstanding; no command is accepted before the previous response completes.

Reset
REQ-018 While rst_n=0, outputs SHALL be:
  - state=IDLE.
  - s_cmd_accept=1.
  - s_data_accept=0.
  - s_resp=NULL, s_resp_last=0, s_data=0, s_tagid=0.
  - Internal counters and flags reset to 0.
REQ-019 Memory contents SHALL NOT be reset; reset mid-burst SHALL abandon the transaction, leaving words already written updated.

Structure
REQ-020 Package ocp_pkg SHALL hold the cmd, resp, and burst_seq enumerations and the FSM state typedef.
REQ-021 Storage SHALL be a sub-module ocp_mem_array: byte-enabled single-port RAM, synchronous write, combinational read.

Verification
REQ-022 Write then read:
  - WR addr=2, blen=4, INCR, tag=5, data 0xA0..0xA3, last on beat 4 -> one DVA, s_tagid=5, s_resp_last=1.
  - RD addr=2, blen=4 -> beats 0xA0..0xA3, s_resp_last only on the 4th beat.
REQ-023 Wrap: WR addr=31, blen=2 data 0x11,0x22 -> mem[31]=0x11, mem[0]=0x22; a read confirms.
REQ-024 Byte enables: mem[3]=0xFFFFFFFF, WR addr=3, byteen=4'b0101, data 0x12345678 -> readback 0xFF34FF78.
REQ-025 Back-pressure: RD blen=3 with m_resp_accept low 4 cycles on beat 2 -> beat 2 data/tag stable throughout, s_cmd_accept=0 until the final accept.
REQ-026 Errors, each -> single ERR, s_resp_last=1, no memory change:
  - burst_seq=3'b001.
  - blen=0.
  - m_cmd=3'b111.
  - WR blen=4 with m_data_last on beat 2.
REQ-027 Reset mid read burst -> all outputs reach their reset values asynchronously; the next command is accepted normally.

Source files
------------

// File: rtl/ocp_pkg.sv
// Shared OCP encodings and slave FSM state type.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package ocp_pkg;

    typedef enum logic [2:0] {
        CMD_IDLE = 3'b000,
        CMD_WR   = 3'b001,
        CMD_RD   = 3'b010
    } ocp_cmd_e;

    typedef enum logic [1:0] {
        RESP_NULL = 2'b00,
        RESP_DVA  = 2'b01,
        RESP_ERR  = 2'b11
    } ocp_resp_e;

    typedef enum logic [2:0] {
        BSEQ_INCR = 3'b000
    } ocp_burst_seq_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_DATA,
        ST_WR_RESP,
        ST_RD_RESP,
        ST_ERR_RESP
    } ocp_state_e;

endpackage

// File: rtl/ocp_mem_array.sv
// Byte-enabled single-port RAM backing the OCP slave.
// Latency: write lands on the clock edge, read is combinational.
// Backpressure: none, accepts a write every cycle.
module ocp_mem_array #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                    clk,
    input  logic                    we,
    input  logic [ADDR_WIDTH-1:0]   addr,
    input  logic [DATA_WIDTH/8-1:0] be,
    input  logic [DATA_WIDTH-1:0]   wdata,
    output logic [DATA_WIDTH-1:0]   rdata
);

    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

    // Contents are deliberately not reset so data survives a transaction abort.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < DATA_WIDTH/8; b++) begin
                if (be[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/ocp_slave_mem.sv
// OCP burst slave: one outstanding transaction against a small word memory.
// Latency: first read beat / write response the cycle after the command or last data beat.
// Backpressure: every response beat holds until m_resp_accept; no command accepted meanwhile.
module ocp_slave_mem
    import ocp_pkg::*;
#(
    parameter int TAGI_WIDTH = 5,
    parameter int INFO_WIDTH = 4,
    parameter int BLEN_WIDTH = 4,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [ADDR_WIDTH-1:0]   m_addr,
    input  logic [BLEN_WIDTH-1:0]   m_burst_length,
    input  logic [2:0]              m_burst_seq,
    input  logic [DATA_WIDTH/8-1:0] m_byteen,
    input  logic [2:0]              m_cmd,
    input  logic [DATA_WIDTH-1:0]   m_data,
    input  logic [DATA_WIDTH/8-1:0] m_data_byteen,
    input  logic                    m_data_last,
    input  logic [TAGI_WIDTH-1:0]   m_data_tagid,
    input  logic                    m_data_valid,
    input  logic [INFO_WIDTH-1:0]   m_req_info,
    input  logic                    m_resp_accept,
    input  logic [TAGI_WIDTH-1:0]   m_tagid,
    output logic                    s_cmd_accept,
    output logic [DATA_WIDTH-1:0]   s_data,
    output logic                    s_data_accept,
    output logic [1:0]              s_resp,
    output logic                    s_resp_last,
    output logic [TAGI_WIDTH-1:0]   s_tagid
);

    ocp_state_e              state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [BLEN_WIDTH-1:0]   blen_q;
    logic [BLEN_WIDTH-1:0]   beat_q;
    logic [TAGI_WIDTH-1:0]   tag_q;
    logic                    err_q;

    logic [BLEN_WIDTH-1:0]   beat_nxt;
    logic                    last_beat;
    logic                    req_err;
    logic                    wr_end;
    logic                    wr_err;
    logic                    mem_we;
    logic [ADDR_WIDTH-1:0]   mem_addr;
    logic [DATA_WIDTH-1:0]   mem_rdata;
    logic                    unused_inputs;

    assign unused_inputs = ^{m_byteen, m_data_tagid, m_req_info};

    // Beat counter wraps in BLEN_WIDTH bits, so a zero length only ends after 2**BLEN_WIDTH beats.
    assign beat_nxt  = beat_q + BLEN_WIDTH'(1);
    assign last_beat = (beat_nxt == blen_q);
    assign mem_addr  = addr_q + ADDR_WIDTH'(beat_q);

    assign req_err = (m_burst_seq != BSEQ_INCR) || (m_burst_length == '0) ||
                     !((m_cmd == CMD_WR) || (m_cmd == CMD_RD));

    always_comb begin
        state_d       = state_q;
        s_cmd_accept  = 1'b0;
        s_data_accept = 1'b0;
        s_resp        = RESP_NULL;
        s_resp_last   = 1'b0;
        s_data        = '0;
        s_tagid       = '0;
        mem_we        = 1'b0;
        wr_end        = 1'b0;
        wr_err        = 1'b0;
        case (state_q)
            ST_IDLE: begin
                s_cmd_accept = 1'b1;
                if (m_cmd != CMD_IDLE) begin
                    if (m_cmd == CMD_WR)       state_d = ST_WR_DATA;
                    else if (!req_err)         state_d = ST_RD_RESP;
                    else                       state_d = ST_ERR_RESP;
                end
            end
            ST_WR_DATA: begin
                s_data_accept = 1'b1;
                if (m_data_valid) begin
                    mem_we = !err_q;
                    wr_end = m_data_last || last_beat;
                    wr_err = err_q || (m_data_last != last_beat);
                    if (wr_end) state_d = wr_err ? ST_ERR_RESP : ST_WR_RESP;
                end
            end
            ST_WR_RESP: begin
                s_resp      = RESP_DVA;
                s_resp_last = 1'b1;
                s_tagid     = tag_q;
                if (m_resp_accept) state_d = ST_IDLE;
            end
            ST_RD_RESP: begin
                s_resp      = RESP_DVA;
                s_resp_last = last_beat;
                s_data      = mem_rdata;
                s_tagid     = tag_q;
                if (m_resp_accept && last_beat) state_d = ST_IDLE;
            end
            ST_ERR_RESP: begin
                s_resp      = RESP_ERR;
                s_resp_last = 1'b1;
                s_tagid     = tag_q;
                if (m_resp_accept) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            blen_q  <= '0;
            beat_q  <= '0;
            tag_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (s_cmd_accept && (m_cmd != CMD_IDLE)) begin
                addr_q <= m_addr;
                blen_q <= m_burst_length;
                tag_q  <= m_tagid;
                err_q  <= req_err;
                beat_q <= '0;
            end else if (state_q == ST_WR_DATA && m_data_valid) begin
                beat_q <= wr_end ? '0 : beat_nxt;
                if (wr_end) err_q <= wr_err;
            end else if (state_q == ST_RD_RESP && m_resp_accept) begin
                beat_q <= last_beat ? '0 : beat_nxt;
            end
        end
    end

    ocp_mem_array #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_mem (
        .clk   (clk),
        .we    (mem_we),
        .addr  (mem_addr),
        .be    (m_data_byteen),
        .wdata (m_data),
        .rdata (mem_rdata)
    );

endmodule

// File: tb/tb_ocp_slave_mem.sv
// Bench for ocp_slave_mem: directed corner cases plus random transactions
// against an array model of the memory and the transaction rules.
module tb_ocp_slave_mem;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [4:0]  m_addr = '0;
    logic [3:0]  m_burst_length = '0;
    logic [2:0]  m_burst_seq = '0;
    logic [3:0]  m_byteen = '0;
    logic [2:0]  m_cmd = '0;
    logic [31:0] m_data = '0;
    logic [3:0]  m_data_byteen = '0;
    logic        m_data_last = 1'b0;
    logic [4:0]  m_data_tagid = '0;
    logic        m_data_valid = 1'b0;
    logic [3:0]  m_req_info = '0;
    logic        m_resp_accept = 1'b0;
    logic [4:0]  m_tagid = '0;
    logic        s_cmd_accept;
    logic [31:0] s_data;
    logic        s_data_accept;
    logic [1:0]  s_resp;
    logic        s_resp_last;
    logic [4:0]  s_tagid;

    int n_chk = 0;
    int n_err = 0;
    logic [31:0] ref_mem [32];
    logic [31:0] wdat [16];
    logic [3:0]  wbe  [16];

    always #5 clk = ~clk;

    ocp_slave_mem dut (
        .clk(clk), .rst_n(rst_n), .m_addr(m_addr), .m_burst_length(m_burst_length),
        .m_burst_seq(m_burst_seq), .m_byteen(m_byteen), .m_cmd(m_cmd), .m_data(m_data),
        .m_data_byteen(m_data_byteen), .m_data_last(m_data_last), .m_data_tagid(m_data_tagid),
        .m_data_valid(m_data_valid), .m_req_info(m_req_info), .m_resp_accept(m_resp_accept),
        .m_tagid(m_tagid), .s_cmd_accept(s_cmd_accept), .s_data(s_data),
        .s_data_accept(s_data_accept), .s_resp(s_resp), .s_resp_last(s_resp_last),
        .s_tagid(s_tagid)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_cmd_accept"},  s_cmd_accept, 1);
        check_eq({tag, "_data_accept"}, s_data_accept, 0);
        check_eq({tag, "_resp"},        s_resp, 0);
        check_eq({tag, "_resp_last"},   s_resp_last, 0);
        check_eq({tag, "_data"},        s_data, 0);
        check_eq({tag, "_tagid"},       s_tagid, 0);
    endtask

    // All tasks start and end on a falling edge.
    task automatic send_cmd(input logic [2:0] cmd, input logic [4:0] addr, input logic [3:0] blen,
                            input logic [2:0] seq, input logic [4:0] tag);
        check_eq("idle_before_cmd", s_cmd_accept, 1);
        m_cmd = cmd; m_addr = addr; m_burst_length = blen; m_burst_seq = seq; m_tagid = tag;
        m_byteen = 4'($urandom); m_req_info = 4'($urandom);
        @(negedge clk);
        m_cmd = 3'b000;
    endtask

    task automatic get_resp(input logic [1:0] er, input logic el, input logic [4:0] et, input bit ct,
                            input logic [31:0] ed, input bit cd, input int stall);
        m_resp_accept = 1'b0;
        for (int s = 0; s <= stall; s++) begin
            check_eq("resp_code", s_resp, er);
            check_eq("resp_last", s_resp_last, el);
            check_eq("busy_no_cmd_accept", s_cmd_accept, 0);
            if (ct) check_eq("resp_tag", s_tagid, et);
            if (cd) check_eq("resp_data", s_data, ed);
            if (s < stall) @(negedge clk);
        end
        m_resp_accept = 1'b1;
        @(negedge clk);
        m_resp_accept = 1'b0;
    endtask

    task automatic wr_txn(input logic [4:0] addr, input logic [3:0] blen, input logic [2:0] seq,
                          input logic [4:0] tag, input int lastpos, input int stall);
        bit req_err;
        bit err;
        int eff;
        int n;
        req_err = (seq != 3'b000) || (blen == 0);
        eff = (blen == 0) ? 16 : int'(blen);
        n = (lastpos >= 1 && lastpos <= eff) ? lastpos : eff;
        err = req_err || ((lastpos == n) != (n == eff));
        send_cmd(3'b001, addr, blen, seq, tag);
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                m_data_valid = 1'b0;
                check_eq("data_accept_gap", s_data_accept, 1);
                @(negedge clk);
            end
            check_eq("data_accept", s_data_accept, 1);
            check_eq("no_resp_in_data", s_resp, 0);
            m_data_valid = 1'b1; m_data = wdat[i]; m_data_byteen = wbe[i];
            m_data_last = (i + 1 == lastpos); m_data_tagid = 5'($urandom);
            @(negedge clk);
            if (!req_err)
                for (int b = 0; b < 4; b++)
                    if (wbe[i][b]) ref_mem[(int'(addr) + i) % 32][8*b +: 8] = wdat[i][8*b +: 8];
        end
        m_data_valid = 1'b0; m_data_last = 1'b0;
        check_eq("data_accept_done", s_data_accept, 0);
        get_resp(err ? 2'b11 : 2'b01, 1'b1, tag, !err, 32'h0, err, stall);
        check_eq("idle_after_wr", s_cmd_accept, 1);
    endtask

    task automatic rd_txn(input logic [4:0] addr, input logic [3:0] blen, input logic [2:0] seq,
                          input logic [4:0] tag, input int stall_beat, input int stall_len,
                          input bit rnd);
        int st;
        send_cmd(3'b010, addr, blen, seq, tag);
        if (seq != 3'b000 || blen == 0) begin
            get_resp(2'b11, 1'b1, tag, 1'b0, 32'h0, 1'b1, rnd ? $urandom_range(0, 2) : 0);
        end else begin
            for (int i = 0; i < int'(blen); i++) begin
                st = (i == stall_beat) ? stall_len : (rnd ? $urandom_range(0, 2) : 0);
                get_resp(2'b01, i == int'(blen) - 1, tag, 1'b1, ref_mem[(int'(addr) + i) % 32],
                         1'b1, st);
            end
        end
        check_eq("idle_after_rd", s_cmd_accept, 1);
        check_eq("null_after_rd", s_resp, 0);
    endtask

    task automatic bad_cmd_txn(input logic [2:0] cmd, input logic [4:0] tag);
        send_cmd(cmd, 5'($urandom), 4'($urandom_range(1, 15)), 3'b000, tag);
        get_resp(2'b11, 1'b1, tag, 1'b0, 32'h0, 1'b1, $urandom_range(0, 2));
        check_eq("idle_after_bad", s_cmd_accept, 1);
    endtask

    task automatic fill_rand(input int n);
        for (int i = 0; i < n; i++) begin
            wdat[i] = $urandom;
            wbe[i]  = ($urandom_range(0, 1) == 0) ? 4'hF : 4'($urandom);
        end
    endtask

    initial begin
        int kind;
        logic [3:0] bl;
        #1;
        check_reset_outputs("reset");
        repeat (2) @(negedge clk);
        check_reset_outputs("reset_held");
        rst_n = 1'b1;
        @(negedge clk);

        // Fill the whole memory so every model word is defined.
        for (int i = 0; i < 16; i++) wbe[i] = 4'hF;
        for (int i = 0; i < 16; i++) wdat[i] = $urandom;
        wr_txn(5'd0, 4'd15, 3'b000, 5'd1, 15, 0);
        for (int i = 0; i < 16; i++) wdat[i] = $urandom;
        wr_txn(5'd15, 4'd15, 3'b000, 5'd2, 15, 1);
        for (int i = 0; i < 16; i++) wdat[i] = $urandom;
        wr_txn(5'd30, 4'd2, 3'b000, 5'd3, 2, 0);

        // Write then read back a four-beat burst.
        for (int i = 0; i < 4; i++) begin wdat[i] = 32'hA0 + i; wbe[i] = 4'hF; end
        wr_txn(5'd2, 4'd4, 3'b000, 5'd5, 4, 0);
        rd_txn(5'd2, 4'd4, 3'b000, 5'd5, -1, 0, 1'b0);

        // Address wrap from the top word to word 0.
        wdat[0] = 32'h11; wdat[1] = 32'h22; wbe[0] = 4'hF; wbe[1] = 4'hF;
        wr_txn(5'd31, 4'd2, 3'b000, 5'd6, 2, 0);
        rd_txn(5'd31, 4'd2, 3'b000, 5'd6, -1, 0, 1'b0);

        // Partial byte enables over an all-ones word.
        wdat[0] = 32'hFFFF_FFFF; wbe[0] = 4'hF;
        wr_txn(5'd3, 4'd1, 3'b000, 5'd7, 1, 0);
        wdat[0] = 32'h1234_5678; wbe[0] = 4'b0101;
        wr_txn(5'd3, 4'd1, 3'b000, 5'd7, 1, 0);
        rd_txn(5'd3, 4'd1, 3'b000, 5'd7, -1, 0, 1'b0);
        check_eq("byteen_model", ref_mem[3], 32'hFF34_FF78);

        // Response back-pressure on the second read beat.
        rd_txn(5'd8, 4'd3, 3'b000, 5'd9, 1, 4, 1'b0);

        // Error cases: bad sequence, zero length, bad command, early last.
        fill_rand(4);
        wr_txn(5'd4, 4'd2, 3'b001, 5'd10, 2, 0);
        rd_txn(5'd4, 4'd2, 3'b001, 5'd10, -1, 0, 1'b0);
        rd_txn(5'd4, 4'd0, 3'b000, 5'd11, -1, 0, 1'b0);
        bad_cmd_txn(3'b111, 5'd12);
        for (int i = 0; i < 4; i++) begin wdat[i] = ref_mem[12 + i]; wbe[i] = 4'hF; end
        wr_txn(5'd12, 4'd4, 3'b000, 5'd13, 2, 0);
        rd_txn(5'd0, 4'd15, 3'b000, 5'd14, -1, 0, 1'b0);

        // Reset in the middle of a read burst.
        send_cmd(3'b010, 5'd20, 4'd8, 3'b000, 5'd15);
        get_resp(2'b01, 1'b0, 5'd15, 1'b1, ref_mem[20], 1'b1, 0);
        get_resp(2'b01, 1'b0, 5'd15, 1'b1, ref_mem[21], 1'b1, 1);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("rst_mid_rd");
        @(negedge clk);
        check_reset_outputs("rst_mid_rd_held");
        rst_n = 1'b1;
        @(negedge clk);
        rd_txn(5'd20, 4'd2, 3'b000, 5'd16, -1, 0, 1'b0);

        // Reset in the middle of a write burst keeps the beats already written.
        fill_rand(6);
        send_cmd(3'b001, 5'd10, 4'd6, 3'b000, 5'd17);
        for (int i = 0; i < 3; i++) begin
            m_data_valid = 1'b1; m_data = wdat[i]; m_data_byteen = wbe[i]; m_data_last = 1'b0;
            @(negedge clk);
            for (int b = 0; b < 4; b++)
                if (wbe[i][b]) ref_mem[10 + i][8*b +: 8] = wdat[i][8*b +: 8];
        end
        m_data_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("rst_mid_wr");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        rd_txn(5'd10, 4'd6, 3'b000, 5'd18, -1, 0, 1'b1);

        // Random mix.
        for (int t = 0; t < 80; t++) begin
            kind = $urandom_range(0, 9);
            bl = 4'($urandom_range(1, 15));
            fill_rand(16);
            if (kind < 4)
                wr_txn(5'($urandom), bl, 3'b000, 5'($urandom), int'(bl), $urandom_range(0, 2));
            else if (kind < 8)
                rd_txn(5'($urandom), bl, 3'b000, 5'($urandom), -1, 0, 1'b1);
            else
                case ($urandom_range(0, 3))
                    0: wr_txn(5'($urandom), bl, 3'($urandom_range(1, 7)), 5'($urandom),
                              int'(bl), 0);
                    1: wr_txn(5'($urandom), 4'd0, 3'b000, 5'($urandom),
                              $urandom_range(0, 16), 0);
                    2: bad_cmd_txn(3'($urandom_range(3, 7)), 5'($urandom));
                    default: wr_txn(5'($urandom), bl, 3'b000, 5'($urandom),
                                    $urandom_range(0, 16), 1);
                endcase
        end
        rd_txn(5'd0, 4'd15, 3'b000, 5'd19, -1, 0, 1'b1);
        rd_txn(5'd15, 4'd15, 3'b000, 5'd20, -1, 0, 1'b1);
        rd_txn(5'd30, 4'd2, 3'b000, 5'd21, -1, 0, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
